// File: rtl/user_input_multi_if.sv
// ---------------------------------------------------------------------------
// user_input_multi_if
//   Signal bundle between raw key/switch pins and the input conditioner.
//
//   in     : raw asynchronous inputs, active-high (1 = pressed)
//   out    : one-cycle event pulses, one bit per channel
//   level  : debounced, filtered input level
//   held   : high while a channel is in auto-repeat (HELD) state
//
//   master : the side that drives raw inputs and consumes the conditioned
//            pulses and levels (board glue / game FSMs)
//   slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface user_input_multi_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] held;

    modport master (
        output in,
        input  out,
        input  level,
        input  held
    );

    modport slave (
        input  in,
        output out,
        output level,
        output held
    );
endinterface

// File: rtl/user_input_multi.sv
// ---------------------------------------------------------------------------
// user_input_multi
//   Multi-channel key conditioner. Each channel is independent and contains
//   a two-flop synchroniser, a debounce filter, a registered one-cycle event
//   pulse on the selected edge and an optional auto-repeat FSM.
//
//   Ports:
//     clock : system clock, rising edge
//     reset : asynchronous active-low reset
//     bus   : user_input_multi_if.slave (in / out / level / held)
//
//   Parameters:
//     WIDTH           : number of channels
//     DEBOUNCE_CYCLES : stable cycles needed before level flips (>= 1)
//     EDGE_MODE       : 0 = pulse on release, 1 = pulse on press
//     REPEAT_EN       : 1 = auto-repeat while held
//     HOLD_CYCLES     : held cycles before the first repeat pulse (>= 1)
//     REPEAT_CYCLES   : cycles between later repeat pulses (>= 1)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// user_input_chan
//   One conditioner channel.
//
//   Ports:
//     clock, reset : as above
//     in_raw       : raw asynchronous input
//     out          : registered one-cycle event pulse
//     level        : debounced level
//     held         : channel is in HELD state
// ---------------------------------------------------------------------------
module user_input_chan #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic in_raw,
    output logic out,
    output logic level,
    output logic held
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] dcnt;
    state_t        state;
    state_t        state_n;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_n;
    logic          flip;
    logic          rise;
    logic          fall;
    logic          tick;
    logic          out_n;

    // The filtered level flips on this edge; rise/fall are therefore
    // aligned with the edge on which level shows its new value, so the
    // registered pulse and the FSM transition land on that same edge.
    assign flip = (sync2 != level) && (dcnt == DB_LAST);
    assign rise = flip & ~level;
    assign fall = flip &  level;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dcnt  <= '0;
            level <= 1'b0;
            state <= IDLE;
            hcnt  <= '0;
            out   <= 1'b0;
        end else begin
            sync1 <= in_raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                dcnt <= '0;
            end else if (dcnt == DB_LAST) begin
                dcnt  <= '0;
                level <= ~level;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
            state <= state_n;
            hcnt  <= hcnt_n;
            out   <= out_n;
        end
    end

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        tick    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESSED;
                    hcnt_n  = '0;
                end
            end
            PRESSED: begin
                if (REPEAT_EN != 0) begin
                    if (hcnt == HOLD_LAST) begin
                        tick    = 1'b1;
                        hcnt_n  = '0;
                        state_n = HELD;
                    end else begin
                        hcnt_n = hcnt + 1'b1;
                    end
                end
                // Release wins over the hold transition; a coincident tick
                // still merges into the single pulse for this cycle.
                if (fall) begin
                    state_n = IDLE;
                    hcnt_n  = '0;
                end
            end
            HELD: begin
                if (hcnt == REP_LAST) begin
                    tick   = 1'b1;
                    hcnt_n = '0;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
                if (fall) begin
                    state_n = IDLE;
                    hcnt_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                hcnt_n  = '0;
            end
        endcase
        // Edge event and repeat tick share one output bit, so a coincident
        // release and tick produce exactly one pulse.
        out_n = tick | ((EDGE_MODE != 0) ? rise : fall);
    end

    assign held = (state == HELD);
endmodule

module user_input_multi #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_EN       = 0,
    parameter int HOLD_CYCLES     = 1000,
    parameter int REPEAT_CYCLES   = 200
) (
    input  logic                clock,
    input  logic                reset,
    user_input_multi_if.slave   bus
);
    logic [WIDTH-1:0] out_w;
    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] held_w;

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        user_input_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .EDGE_MODE       (EDGE_MODE),
            .REPEAT_EN       (REPEAT_EN),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .in_raw (bus.in[g]),
            .out    (out_w[g]),
            .level  (level_w[g]),
            .held   (held_w[g])
        );
    end

    assign bus.out   = out_w;
    assign bus.level = level_w;
    assign bus.held  = held_w;
endmodule

// File: tb/tb_user_input_multi.sv
// ---------------------------------------------------------------------------
// tb_user_input_multi
//   Directed bench for user_input_multi. Four DUT instances with different
//   parameter sets share clock and reset; each scenario drives one of them.
//   Inputs change and outputs are sampled on the falling clock edge; loop
//   index k counts rising edges since the input change.
// ---------------------------------------------------------------------------
module tb_user_input_multi;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    user_input_multi_if #(.WIDTH(1)) bus0 ();
    user_input_multi_if #(.WIDTH(1)) bus1 ();
    user_input_multi_if #(.WIDTH(1)) bus2 ();
    user_input_multi_if #(.WIDTH(4)) bus3 ();

    // release-edge, no repeat
    user_input_multi #(.WIDTH(1), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .REPEAT_EN(0),
                       .HOLD_CYCLES(1000), .REPEAT_CYCLES(200))
        u_d0 (.clock(clock), .reset(reset), .bus(bus0));
    // press-edge, no repeat
    user_input_multi #(.WIDTH(1), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .REPEAT_EN(0),
                       .HOLD_CYCLES(1000), .REPEAT_CYCLES(200))
        u_d1 (.clock(clock), .reset(reset), .bus(bus1));
    // press-edge with auto-repeat
    user_input_multi #(.WIDTH(1), .DEBOUNCE_CYCLES(2), .EDGE_MODE(1), .REPEAT_EN(1),
                       .HOLD_CYCLES(8), .REPEAT_CYCLES(3))
        u_d2 (.clock(clock), .reset(reset), .bus(bus2));
    // four channels, press-edge
    user_input_multi #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .REPEAT_EN(0),
                       .HOLD_CYCLES(1000), .REPEAT_CYCLES(200))
        u_d3 (.clock(clock), .reset(reset), .bus(bus3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus0.in = '0;
        bus1.in = '0;
        bus2.in = '0;
        bus3.in = '0;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        chk("rst_lvl0",  32'(bus0.level), 32'd0);
        chk("rst_out3",  32'(bus3.out),   32'd0);
        chk("rst_held2", 32'(bus2.held),  32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_out0", 32'(bus0.out),   32'd0);
        chk("post_rst_lvl3", 32'(bus3.level), 32'd0);

        // ---- A: press 10 cycles, release; pulse only on release ----
        bus0.in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            chk("A_press_lvl", 32'(bus0.level), 32'(k >= 6));
            chk("A_press_out", 32'(bus0.out),   32'd0);
        end
        bus0.in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            chk("A_rel_out", 32'(bus0.out),   32'(k == 6));
            chk("A_rel_lvl", 32'(bus0.level), 32'(k < 6));
        end

        // ---- B: 3-cycle glitch never changes level ----
        bus0.in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            chk("B_lvl", 32'(bus0.level), 32'd0);
            chk("B_out", 32'(bus0.out),   32'd0);
            if (k == 3) bus0.in = 1'b0;
        end

        // ---- C: press edge, held 20 cycles, no pulse on release ----
        bus1.in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            chk("C_press_out", 32'(bus1.out),   32'(k == 6));
            chk("C_press_lvl", 32'(bus1.level), 32'(k >= 6));
        end
        bus1.in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            chk("C_rel_out", 32'(bus1.out),   32'd0);
            chk("C_rel_lvl", 32'(bus1.level), 32'(k < 6));
        end

        // ---- D: auto-repeat; press at 4, hold pulse at 12, then every 3 ----
        // Input drops before edge 20, so level falls at edge 23 (no tick there).
        bus2.in = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            chk("D_out",  32'(bus2.out),
                32'(k == 4 || k == 12 || k == 15 || k == 18 || k == 21));
            chk("D_held", 32'(bus2.held),  32'(k >= 12 && k < 23));
            chk("D_lvl",  32'(bus2.level), 32'(k >= 4 && k < 23));
            if (k == 19) bus2.in = 1'b0;
        end

        // ---- E: 4 channels; 0 and 3 pressed together, 1 bouncing ----
        bus3.in = 4'b1011;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            chk("E_out",  32'(bus3.out), (k == 6) ? 32'h9 : 32'h0);
            chk("E_lvl1", 32'(bus3.level[1]), 32'd0);
            bus3.in[1] = ~bus3.in[1];
        end
        chk("E_lvl_end", 32'(bus3.level), 32'h9);
        bus3.in = 4'b0000;

        // ---- F: async reset in HELD, then fresh press after release ----
        bus2.in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            chk("F_out",  32'(bus2.out),  32'(k == 4 || k == 12));
            chk("F_held", 32'(bus2.held), 32'(k >= 12));
        end
        #2 reset = 1'b0;
        #1;
        chk("F_async_out",  32'(bus2.out),   32'd0);
        chk("F_async_lvl",  32'(bus2.level), 32'd0);
        chk("F_async_held", 32'(bus2.held),  32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            chk("F_re_out", 32'(bus2.out),   32'(k == 4));
            chk("F_re_lvl", 32'(bus2.level), 32'(k >= 4));
            chk("F_re_held", 32'(bus2.held), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/user_input_multi.md
Name: user_input_multi

Overview:
- Parametrised, multi-channel successor to the single-channel one-shot key conditioner.
- Per channel: two-flop synchroniser, debounce filter, one-cycle event pulse on a selectable edge (press or release), and optional auto-repeat while a key is held.
- Sits between raw KEY/SW pins and game/control FSMs. Downstream logic consumes only single-cycle pulses and clean levels.

Parameters:
- WIDTH, 4: number of independent input channels.
- DEBOUNCE_CYCLES, 16: consecutive cycles the synchronised input must differ from the filtered level before the level flips. Legal range is at least 1.
- EDGE_MODE, 0: which edge generates the event pulse. 0 = release (1->0 of the filtered level); 1 = press (0->1).
- REPEAT_EN, 0: 1 enables auto-repeat pulses while a channel is held.
- HOLD_CYCLES, 1000: cycles of continuous filtered-high before the first repeat pulse. Legal range is at least 1.
- REPEAT_CYCLES, 200: interval between subsequent repeat pulses. Legal range is at least 1.

Ports:
- clock, input, 1: system clock. All state is updated on its rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserts immediately when low; deasserts on the clock edge.
- in, input, WIDTH: raw asynchronous inputs, active-high (1 = pressed). Board-level inversion of KEY pins is done outside this block.
- out, output, WIDTH: one-cycle event pulses, one bit per channel.
- level, output, WIDTH: debounced, filtered input level.
- held, output, WIDTH: high while the channel is in HELD state (auto-repeat active).

Behaviour:
- Reset (reset low): all synchroniser flops, level, out and held = 0; all counters = 0; every channel FSM = IDLE.
- Reset takes effect asynchronously mid-operation. Any in-flight pulse is dropped. No pulse is generated on reset release, even if in = 1. A held input is then treated as a new press after debounce.
- Channels are fully independent. There is no shared state, and any combination of simultaneous events is legal.
- Synchroniser: sync = in after two flops.
- Debounce counter (per channel, width $clog2(DEBOUNCE_CYCLES+1)):
  - If sync == level, the counter clears to 0.
  - Otherwise it increments.
  - When it is at DEBOUNCE_CYCLES-1 and sync != level, level toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles (in synchronised time) never changes level.
- Latency: if in changes before edge 1 and stays stable, level changes on edge 2+DEBOUNCE_CYCLES.
- Event pulse (registered): out[i] = 1 for exactly the cycle in which level[i] first shows the new value.
  - EDGE_MODE=1: pulse on the 0->1 level transition.
  - EDGE_MODE=0: pulse on the 1->0 level transition.
  - Holding does not generate extra pulses unless auto-repeat is enabled.
- Per-channel FSM states: IDLE, PRESSED, HELD.
  - IDLE -> PRESSED when level rises. The hold counter clears.
  - PRESSED:
    - When level falls, go to IDLE.
    - Otherwise, if REPEAT_EN=1, the hold counter increments each cycle. When it reaches HOLD_CYCLES-1, go to HELD, pulse out[i] on that transition edge, and clear the counter.
  - HELD:
    - held[i] = 1.
    - The counter increments. At REPEAT_CYCLES-1, pulse out[i] and clear the counter.
    - When level falls, go to IDLE and clear held on the same edge.
  - If REPEAT_EN=0, PRESSED never advances to HELD and held stays 0.
- Repeat pulses are emitted in both EDGE_MODEs. In EDGE_MODE=0 the release pulse is still emitted on exit from PRESSED or HELD.
- If a repeat tick and the release edge coincide, exactly one pulse is issued for that cycle. out is never high for two consecutive cycles from a single event.
- Counters saturate or wrap only under the stated clears. They never overflow because each is sized by $clog2 of its limit.

Test Plan:
- WIDTH=1, DEBOUNCE_CYCLES=4, EDGE_MODE=0. Reset, drive in=1 for 10 cycles, then 0 -> level rises 6 edges after in rises. out stays 0 while held. A single out pulse occurs 6 edges after in falls.
- Same config, in=1 glitch of 3 cycles -> level stays 0 and out is never asserted.
- EDGE_MODE=1, in held 20 cycles -> exactly one out pulse, coincident with level rising. No pulse on release.
- REPEAT_EN=1, HOLD_CYCLES=8, REPEAT_CYCLES=3, DEBOUNCE_CYCLES=2, EDGE_MODE=1, in held 20 cycles:
  - press pulse at level rise;
  - next pulse 8 cycles later, with held=1 from then;
  - further pulses every 3 cycles;
  - held clears when level falls.
- WIDTH=4: channels 0 and 3 pressed on the same cycle, channel 1 bouncing (alternating every cycle) -> out[0] and out[3] pulse on the same cycle, and out[1] and level[1] stay 0.
- Assert reset (low) mid-HELD between clock edges -> out, level and held clear immediately. On release with in still 1, a fresh press pulse appears after 2+DEBOUNCE_CYCLES edges (EDGE_MODE=1).
